// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU, DMA)
// and the shared data memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [3:0]        cpu_size;
  logic              cpu_stall;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [3:0]        dma_size;
  logic              dma_gnt;
  logic              dma_done;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_size;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size,
    output cpu_stall, cpu_done, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_size,
    output dma_gnt, dma_done, dma_rdata,
    output mem_addr, mem_wdata, mem_size, mem_we, mem_re,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size,
    input  cpu_stall, cpu_done, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_size,
    input  dma_gnt, dma_done, dma_rdata,
    input  mem_addr, mem_wdata, mem_size, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU and a DMA/debug port: CPU has fixed
// priority, DMA is forced in after STARVE_LIM consecutive CPU grants.
module dmem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input logic         clk,
  input logic         reset,
  dmem_arbiter_if.slave bus
);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int ST_W  = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
  localparam logic [ST_W-1:0]  ST_LIM   = ST_W'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ST_W-1:0]   starve_cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        lat_size;

  logic starved;
  logic grant_dma;
  logic grant_cpu;
  logic last;
  logic in_acc;

  assign starved   = (starve_cnt == ST_LIM);
  assign grant_dma = bus.dma_req & (~bus.cpu_req | starved);
  assign grant_cpu = bus.cpu_req & ~grant_dma;
  assign last      = (lat_cnt == '0);
  assign in_acc    = (state != IDLE);

  // A CPU grant with DMA waiting can only happen below the limit, so the
  // increment saturates at STARVE_LIM without an explicit clamp.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_size   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dma) begin
            state      <= DMA_ACC;
            lat_cnt    <= LAT_INIT;
            starve_cnt <= '0;
            lat_we     <= bus.dma_we;
            lat_addr   <= bus.dma_addr;
            lat_wdata  <= bus.dma_wdata;
            lat_size   <= bus.dma_size;
          end else if (grant_cpu) begin
            state      <= CPU_ACC;
            lat_cnt    <= LAT_INIT;
            starve_cnt <= bus.dma_req ? starve_cnt + ST_W'(1) : '0;
            lat_we     <= bus.cpu_we;
            lat_addr   <= bus.cpu_addr;
            lat_wdata  <= bus.cpu_wdata;
            lat_size   <= bus.cpu_size;
          end else begin
            starve_cnt <= '0;
          end
        end
        CPU_ACC, DMA_ACC: begin
          if (last) begin
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.mem_size  = lat_size;
  assign bus.mem_we    = in_acc & lat_we;
  assign bus.mem_re    = in_acc & ~lat_we;

  assign bus.dma_gnt   = (state == DMA_ACC);
  assign bus.cpu_done  = (state == CPU_ACC) & last;
  assign bus.dma_done  = (state == DMA_ACC) & last;
  assign bus.cpu_rdata = bus.cpu_done ? bus.mem_rdata : '0;
  assign bus.dma_rdata = bus.dma_done ? bus.mem_rdata : '0;
  assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cycle checks plus a scoreboard
// of expected completions popped on every done pulse.
module tb_dmem_arbiter;
  localparam int LAT = 2;
  localparam int LIM = 4;

  typedef struct {
    bit          dma;
    bit          we;
    logic [63:0] addr;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus();

  dmem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT), .STARVE_LIM(LIM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content is a fixed function of the address.
  function automatic logic [63:0] word_at(input logic [63:0] a);
    if (a == 64'h10) return 64'hDEAD;
    return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
  endfunction

  assign bus.mem_rdata = word_at(bus.mem_addr);

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input bit dma, input bit req, input bit we,
                                input logic [63:0] addr, input logic [63:0] wdata);
    if (dma) begin
      bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata; bus.dma_size = 4'd4;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_size = 4'd8;
    end
  endtask

  task automatic push_exp(input bit dma, input bit we, input logic [63:0] addr, input logic [63:0] wdata);
    exp_t e;
    e.dma  = dma;
    e.we   = we;
    e.addr = addr;
    e.data = we ? wdata : word_at(addr);
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag, input bit dma);
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = dma ? bus.dma_done : bus.cpu_done;
    end
    check_output(tag, seen, 1);
  endtask

  // Every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.cpu_done === 1'b1 || bus.dma_done === 1'b1) begin
      check_output("one_done", bus.cpu_done & bus.dma_done, 0);
      check_output("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_output("sb_owner", bus.dma_done, e.dma);
        check_output("sb_addr", bus.mem_addr, e.addr);
        check_output("sb_we", bus.mem_we, e.we);
        if (e.we) check_output("sb_wdata", bus.mem_wdata, e.data);
        else      check_output("sb_rdata", e.dma ? bus.dma_rdata : bus.cpu_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ndone;
    reset = 1'b0;
    apply_stimulus(0, 1, 0, 64'h0, 64'h0);
    apply_stimulus(1, 1, 0, 64'h0, 64'h0);

    // Reset with both requests asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_mem_we", bus.mem_we, 0);
    check_output("rst_mem_re", bus.mem_re, 0);
    check_output("rst_cpu_done", bus.cpu_done, 0);
    check_output("rst_dma_done", bus.dma_done, 0);
    check_output("rst_dma_gnt", bus.dma_gnt, 0);
    check_output("rst_cpu_stall", bus.cpu_stall, 1);
    check_output("rst_mem_addr", bus.mem_addr, 0);
    next_cycle;
    apply_stimulus(0, 0, 0, 64'h0, 64'h0);
    apply_stimulus(1, 0, 0, 64'h0, 64'h0);
    reset = 1'b1;
    next_cycle;

    // CPU read of 0x10
    apply_stimulus(0, 1, 0, 64'h10, 64'h0);
    push_exp(0, 0, 64'h10, 64'h0);
    @(negedge clk);
    check_output("t2_arb_stall", bus.cpu_stall, 1);
    check_output("t2_arb_re", bus.mem_re, 0);
    for (int k = 1; k <= LAT; k++) begin
      next_cycle;
      @(negedge clk);
      check_output("t2_re", bus.mem_re, 1);
      check_output("t2_addr", bus.mem_addr, 64'h10);
      check_output("t2_done", bus.cpu_done, k == LAT);
      check_output("t2_stall", bus.cpu_stall, k != LAT);
      if (k != LAT) check_output("t2_rdata_zero", bus.cpu_rdata, 0);
    end
    next_cycle;
    apply_stimulus(0, 0, 0, 64'h0, 64'h0);
    @(negedge clk);
    check_output("t2_idle_re", bus.mem_re, 0);

    // DMA write of 0x1234 to 0x40, CPU idle
    next_cycle;
    apply_stimulus(1, 1, 1, 64'h40, 64'h1234);
    push_exp(1, 1, 64'h40, 64'h1234);
    @(negedge clk);
    check_output("t4_arb_gnt", bus.dma_gnt, 0);
    check_output("t4_arb_stall", bus.cpu_stall, 0);
    for (int k = 1; k <= LAT; k++) begin
      next_cycle;
      @(negedge clk);
      check_output("t4_we", bus.mem_we, 1);
      check_output("t4_re", bus.mem_re, 0);
      check_output("t4_gnt", bus.dma_gnt, 1);
      check_output("t4_wdata", bus.mem_wdata, 64'h1234);
      check_output("t4_size", bus.mem_size, 4);
      check_output("t4_done", bus.dma_done, k == LAT);
      check_output("t4_stall", bus.cpu_stall, 0);
      if (k != LAT) check_output("t4_rdata_zero", bus.dma_rdata, 0);
    end
    next_cycle;
    apply_stimulus(1, 0, 0, 64'h0, 64'h0);
    @(negedge clk);
    check_output("t4_after_gnt", bus.dma_gnt, 0);
    check_output("t4_after_we", bus.mem_we, 0);

    // Reset in the middle of a CPU write; the held request is granted again
    next_cycle;
    apply_stimulus(0, 1, 1, 64'h18, 64'h5555);
    push_exp(0, 1, 64'h18, 64'h5555);
    next_cycle;
    reset = 1'b0;
    @(negedge clk);
    check_output("t5_pre_we", bus.mem_we, 1);
    check_output("t5_pre_done", bus.cpu_done, 0);
    next_cycle;
    @(negedge clk);
    check_output("t5_rst_we", bus.mem_we, 0);
    check_output("t5_rst_done", bus.cpu_done, 0);
    check_output("t5_rst_stall", bus.cpu_stall, 1);
    next_cycle;
    reset = 1'b1;
    @(negedge clk);
    check_output("t5_arb_we", bus.mem_we, 0);
    check_output("t5_arb_stall", bus.cpu_stall, 1);
    for (int k = 1; k <= LAT; k++) begin
      next_cycle;
      @(negedge clk);
      check_output("t5_we", bus.mem_we, 1);
      check_output("t5_done", bus.cpu_done, k == LAT);
    end
    next_cycle;
    apply_stimulus(0, 0, 0, 64'h0, 64'h0);

    // Request fields changing mid-access are ignored
    next_cycle;
    apply_stimulus(0, 1, 0, 64'h10, 64'h0);
    push_exp(0, 0, 64'h10, 64'h0);
    for (int k = 1; k <= LAT; k++) begin
      next_cycle;
      if (k == 1) apply_stimulus(0, 1, 1, 64'h80, 64'hFFFF);
      @(negedge clk);
      check_output("t6_addr", bus.mem_addr, 64'h10);
      check_output("t6_re", bus.mem_re, 1);
    end
    next_cycle;
    apply_stimulus(0, 0, 0, 64'h0, 64'h0);

    // DMA read whose request drops after the grant still completes
    next_cycle;
    apply_stimulus(1, 1, 0, 64'h200, 64'h0);
    push_exp(1, 0, 64'h200, 64'h0);
    next_cycle;
    apply_stimulus(1, 0, 0, 64'h0, 64'h0);
    wait_done("t7_done_timeout", 1);
    next_cycle;
    next_cycle;

    // Both requesters held: CPU wins until the starvation limit forces DMA
    apply_stimulus(0, 1, 0, 64'h100, 64'h0);
    apply_stimulus(1, 1, 0, 64'h200, 64'h0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < LIM; i++) push_exp(0, 0, 64'h100, 64'h0);
      push_exp(1, 0, 64'h200, 64'h0);
    end
    ndone = 0;
    for (int c = 0; c < 200 && ndone < 2 * (LIM + 1); c++) begin
      @(negedge clk);
      if (bus.cpu_done || bus.dma_done) ndone++;
    end
    check_output("t3_count", ndone, 2 * (LIM + 1));
    next_cycle;
    apply_stimulus(0, 0, 0, 64'h0, 64'h0);
    apply_stimulus(1, 0, 0, 64'h0, 64'h0);

    repeat (LAT + 3) next_cycle;
    @(negedge clk);
    check_output("sb_drained", sb.size(), 0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
